// File: rtl/muldiv_sequencer_if.sv
// Request/result bundle between decode and the MULT/DIV sequencer.
// Decode drives the op request; the sequencer returns stall/done status and HI/LO.
interface muldiv_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       alu_control;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             stall;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, alu_control, op_a, op_b,
        input  busy, stall, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, alu_control, op_a, op_b,
        output busy, stall, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative signed MULT (shift-add) / DIV (restoring) engine owning the HI/LO registers.
// Latency: WIDTH+2 cycles from accepted start to done; divide-by-zero finishes in 1 cycle.
// Backpressure: stall holds the pipeline from accept through FIX; starts while busy are dropped.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic                clk,
    input  logic                reset,
    muldiv_sequencer_if.slave   bus
);
    localparam logic [2:0] CTL_MULT = 3'b101;
    localparam logic [2:0] CTL_DIV  = 3'b110;
    localparam int         CW       = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic             is_div;
    logic             sign_a;
    logic             sign_b;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             dbz_q;

    logic             valid_op;
    logic             accept;
    logic             zero_div;
    logic             last_iter;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

    assign valid_op  = (bus.alu_control == CTL_MULT) || (bus.alu_control == CTL_DIV);
    assign accept    = bus.start && valid_op && ((state == S_IDLE) || (state == S_DONE));
    assign zero_div  = (bus.alu_control == CTL_DIV) && (bus.op_b == '0);
    assign last_iter = (cnt == CW'(WIDTH - 1));
    // Negating the most negative value wraps back to itself, which is 2^(WIDTH-1) unsigned.
    assign abs_a     = bus.op_a[WIDTH-1] ? -bus.op_a : bus.op_a;
    assign abs_b     = bus.op_b[WIDTH-1] ? -bus.op_b : bus.op_b;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    state_nxt = zero_div ? S_DONE : S_RUN;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (last_iter) begin
                    state_nxt = S_FIX;
                end
            end
            S_FIX:   state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // One iteration of each algorithm, computed from the current accumulator.
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   mul_hi_nxt;
    logic [WIDTH-1:0]   mul_lo_nxt;
    logic [WIDTH:0]     rem_sh;
    logic               div_ge;
    logic [WIDTH-1:0]   rem_diff;
    logic [WIDTH-1:0]   div_hi_nxt;
    logic [WIDTH-1:0]   div_lo_nxt;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    always_comb begin
        mul_sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        mul_hi_nxt = mul_sum[WIDTH:1];
        mul_lo_nxt = {mul_sum[0], acc_lo[WIDTH-1:1]};

        rem_sh     = {acc_hi, acc_lo[WIDTH-1]};
        div_ge     = (rem_sh >= {1'b0, opnd});
        rem_diff   = rem_sh[WIDTH-1:0] - opnd;
        div_hi_nxt = div_ge ? rem_diff : rem_sh[WIDTH-1:0];
        div_lo_nxt = {acc_lo[WIDTH-2:0], div_ge};

        prod_fix   = (sign_a ^ sign_b) ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
        quot_fix   = (sign_a ^ sign_b) ? -acc_lo : acc_lo;
        rem_fix    = sign_a ? -acc_hi : acc_hi;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            is_div <= 1'b0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            opnd   <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            dbz_q  <= 1'b0;
        end else if (accept) begin
            is_div <= (bus.alu_control == CTL_DIV);
            sign_a <= bus.op_a[WIDTH-1];
            sign_b <= bus.op_b[WIDTH-1];
            cnt    <= '0;
            acc_hi <= '0;
            dbz_q  <= 1'b0;
            // MULT keeps the multiplier in acc_lo; DIV keeps the dividend there as the quotient seed.
            if (bus.alu_control == CTL_DIV) begin
                acc_lo <= abs_a;
                opnd   <= abs_b;
            end else begin
                acc_lo <= abs_b;
                opnd   <= abs_a;
            end
            if (zero_div) begin
                hi_q  <= bus.op_a;
                lo_q  <= '1;
                dbz_q <= 1'b1;
            end
        end else if (state == S_RUN) begin
            cnt <= cnt + 1'b1;
            if (is_div) begin
                acc_hi <= div_hi_nxt;
                acc_lo <= div_lo_nxt;
            end else begin
                acc_hi <= mul_hi_nxt;
                acc_lo <= mul_lo_nxt;
            end
        end else if (state == S_FIX) begin
            if (is_div) begin
                hi_q <= rem_fix;
                lo_q <= quot_fix;
            end else begin
                hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                lo_q <= prod_fix[WIDTH-1:0];
            end
        end
    end

    assign bus.busy        = (state == S_RUN) || (state == S_FIX);
    assign bus.stall       = bus.busy || accept;
    assign bus.done        = (state == S_DONE);
    assign bus.div_by_zero = dbz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: expected HI/LO/flag pushed at issue, popped on done.
module tb_muldiv_sequencer;
    localparam logic [2:0] MULT = 3'b101;
    localparam logic [2:0] DIV  = 3'b110;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } res_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    res_t sb[$];
    res_t last_r;

    muldiv_sequencer_if #(.WIDTH(32)) bus ();

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic res_t model(input logic [2:0] ctl, input logic [31:0] a, input logic [31:0] b);
        res_t   r;
        longint p;
        int     sa;
        int     sbv;
        int     q;
        int     m;
        sa  = a;
        sbv = b;
        r.dbz = 1'b0;
        if (ctl == MULT) begin
            p    = longint'(sa) * longint'(sbv);
            r.hi = p[63:32];
            r.lo = p[31:0];
        end else if (b == 32'h0) begin
            r.hi  = a;
            r.lo  = 32'hFFFF_FFFF;
            r.dbz = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r.hi = 32'h0;
            r.lo = 32'h8000_0000;
        end else begin
            q    = sa / sbv;
            m    = sa % sbv;
            r.hi = m;
            r.lo = q;
        end
        return r;
    endfunction

    // Drives a request from the current time, holds it across one edge, and expects acceptance.
    task automatic issue(input logic [2:0] ctl, input logic [31:0] a, input logic [31:0] b);
        res_t r;
        r = model(ctl, a, b);
        bus.start       = 1'b1;
        bus.alu_control = ctl;
        bus.op_a        = a;
        bus.op_b        = b;
        sb.push_back(r);
        last_r = r;
        #1;
        chk("stall_accept", bus.stall, 1);
        @(posedge clk);
        #1;
        bus.start       = 1'b0;
        bus.alu_control = 3'b000;
        chk("dbz_after_accept", bus.div_by_zero, r.dbz);
        chk("busy_after_accept", bus.busy, !r.dbz);
    endtask

    task automatic wait_done(input int exp_lat);
        int n = 0;
        int st = 0;
        bit seen = 0;
        while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            if (bus.done) seen = 1;
            else if (bus.stall) st++;
        end
        chk("done_seen", seen, 1);
        chk("latency", n, exp_lat);
        chk("stall_cycles", st, exp_lat - 1);
        chk("stall_in_done", bus.stall, 0);
    endtask

    always @(negedge clk) begin
        res_t r;
        if (!reset && bus.done) begin
            chk("sb_pending", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                r = sb.pop_front();
                chk("hi", bus.hi, r.hi);
                chk("lo", bus.lo, r.lo);
                chk("dbz", bus.div_by_zero, r.dbz);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.start       = 1'b0;
        bus.alu_control = 3'b000;
        bus.op_a        = 32'h0;
        bus.op_b        = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_stall", bus.stall, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_dbz", bus.div_by_zero, 0);
        chk("rst_hi", bus.hi, 0);
        chk("rst_lo", bus.lo, 0);
        reset = 1'b0;
        @(negedge clk);

        issue(MULT, 32'd7, 32'hFFFF_FFFD);
        wait_done(34);
        issue(MULT, 32'h8000_0000, 32'h8000_0000);
        wait_done(34);
        issue(MULT, 32'h0, 32'hFFFF_FFFF);
        wait_done(34);
        issue(DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(34);
        issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(34);

        issue(DIV, 32'd5, 32'd0);
        wait_done(1);
        @(negedge clk);
        issue(MULT, 32'd3, 32'd4);
        wait_done(34);

        // A request mid-DIV must be dropped; a request in the DONE cycle goes straight in.
        @(negedge clk);
        issue(DIV, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        bus.start       = 1'b1;
        bus.alu_control = MULT;
        bus.op_a        = 32'd2;
        bus.op_b        = 32'd3;
        #1;
        chk("stall_busy", bus.stall, 1);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("busy_ignored", bus.busy, 1);
        wait_done(25);
        issue(MULT, 32'hFFFF_FFFB, 32'd6);
        wait_done(34);
        repeat (3) @(negedge clk);
        chk("hold_hi", bus.hi, last_r.hi);
        chk("hold_lo", bus.lo, last_r.lo);

        for (int i = 0; i < 6; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            b = (i == 5) ? 32'd0 : $urandom_range(0, 1) ? $urandom : $urandom_range(1, 300);
            @(negedge clk);
            issue((i % 2) ? DIV : MULT, a, b);
            wait_done(((i % 2) && b == 32'd0) ? 1 : 34);
        end

        @(negedge clk);
        issue(MULT, 32'd12345, 32'd678);
        repeat (15) @(posedge clk);
        #1;
        reset = 1'b1;
        sb.delete();
        #1;
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_stall", bus.stall, 0);
        chk("mid_rst_done", bus.done, 0);
        chk("mid_rst_hi", bus.hi, 0);
        chk("mid_rst_lo", bus.lo, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        chk("post_rst_busy", bus.busy, 0);

        bus.start       = 1'b1;
        bus.alu_control = 3'b010;
        bus.op_a        = 32'd9;
        bus.op_b        = 32'd3;
        #1;
        chk("bad_ctl_stall", bus.stall, 0);
        @(posedge clk);
        #1;
        chk("bad_ctl_busy", bus.busy, 0);
        chk("bad_ctl_done", bus.done, 0);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("bad_ctl_hi", bus.hi, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
